// File: rtl/bp_gshare_btb_pkg.sv
// Shared constants, types and helpers for the gshare/BTB predictor slice.
//   BTB_LEN  : BTB index width (BTB_BITS entries)
//   GHR_LEN  : GHR width and PHT index width (GHR_BITS counters)
//   SNT/WNT/WT/ST : 2-bit counter encodings
package bp_gshare_btb_pkg;

    localparam int BTB_LEN  = 6;
    localparam int GHR_LEN  = 8;
    localparam int BTB_BITS = 1 << BTB_LEN;
    localparam int GHR_BITS = 1 << GHR_LEN;
    localparam int TAG_W    = 32 - BTB_LEN - 2;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef logic [BTB_LEN-1:0] btb_idx_t;
    typedef logic [GHR_LEN-1:0] ghr_t;
    typedef logic [TAG_W-1:0]   btb_tag_t;

    function automatic btb_tag_t pc_tag(input logic [31:0] pc);
        return pc[31:BTB_LEN+2];
    endfunction

endpackage

// File: rtl/bp_gshare_btb_if.sv
// Predictor bus: IF lookup, PD-side prediction, ID-stage table updates,
// plus the PD-register stall/refresh controls.
//   master : pipeline side (drives lookups, controls, updates; reads prediction)
//   slave  : predictor (bp_gshare_btb)
interface bp_gshare_btb_if;

    logic                          stall;
    logic                          refresh;
    logic                          if_req;
    logic [31:0]                   if_pc;
    logic                          pd_bp_valid;
    logic                          pd_btb_hit;
    logic                          pd_bp_take;
    logic [31:0]                   pd_bp_target;
    bp_gshare_btb_pkg::btb_idx_t   pd_btb_index;
    bp_gshare_btb_pkg::ghr_t       pd_gshare_index;
    logic                          id_btb_wen;
    bp_gshare_btb_pkg::btb_idx_t   id_btb_windex;
    logic [31:0]                   id_btb_wpc;
    logic [31:0]                   id_btb_wtarget;
    logic                          id_gshare_wen;
    bp_gshare_btb_pkg::ghr_t       id_gshare_windex;
    logic                          id_br_taken;

    modport master (
        output stall, refresh, if_req, if_pc,
        output id_btb_wen, id_btb_windex, id_btb_wpc, id_btb_wtarget,
        output id_gshare_wen, id_gshare_windex, id_br_taken,
        input  pd_bp_valid, pd_btb_hit, pd_bp_take, pd_bp_target,
        input  pd_btb_index, pd_gshare_index
    );

    modport slave (
        input  stall, refresh, if_req, if_pc,
        input  id_btb_wen, id_btb_windex, id_btb_wpc, id_btb_wtarget,
        input  id_gshare_wen, id_gshare_windex, id_br_taken,
        output pd_bp_valid, pd_btb_hit, pd_bp_take, pd_bp_target,
        output pd_btb_index, pd_gshare_index
    );

endinterface

// File: rtl/bp_gshare_btb_sat_cnt2.sv
// bp_sat_cnt2: combinational next state of a 2-bit saturating counter.
//   cnt_i   : current counter
//   taken_i : resolved outcome (1 = count up)
//   cnt_o   : next counter, clamped at SNT/ST
module bp_sat_cnt2
    import bp_gshare_btb_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/bp_gshare_btb.sv
// bp_gshare_btb: direct-mapped BTB + gshare PHT + committed GHR.
// Lookup from IF is registered and presented to PD one cycle later;
// ID-stage updates are applied every cycle regardless of stall/refresh.
//   clk, resetn : clock, synchronous active-low reset
//   bp (slave)  : lookup, PD prediction, ID updates, stall/refresh
// Build option: BP_WRITE_FWD_EN forwards same-cycle BTB/PHT writes into
// the lookup (GHR still read pre-shift). Default: strict read-old.
module bp_gshare_btb
    import bp_gshare_btb_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    bp_gshare_btb_if.slave bp
);

    // Tables
    logic       btb_valid_q [BTB_BITS];
    logic       btb_valid_d [BTB_BITS];
    btb_tag_t   btb_tag_q   [BTB_BITS];
    btb_tag_t   btb_tag_d   [BTB_BITS];
    logic [31:0] btb_tgt_q  [BTB_BITS];
    logic [31:0] btb_tgt_d  [BTB_BITS];
    logic [1:0] pht_q       [GHR_BITS];
    logic [1:0] pht_d       [GHR_BITS];
    ghr_t       ghr_q, ghr_d;

    // PD-side output register
    logic        pd_valid_q, pd_valid_d;
    logic        pd_hit_q, pd_hit_d;
    logic        pd_take_q, pd_take_d;
    logic [31:0] pd_tgt_q, pd_tgt_d;
    btb_idx_t    pd_bidx_q, pd_bidx_d;
    ghr_t        pd_gidx_q, pd_gidx_d;

    // Lookup
    btb_idx_t    bidx;
    ghr_t        gidx;
    logic        rd_valid;
    btb_tag_t    rd_tag;
    logic [31:0] rd_tgt;
    logic [1:0]  rd_cnt;
    logic        hit;
    logic [1:0]  pht_wr_cnt;

    // Word-offset PC bits and the index bits of the write PC carry no state.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.id_btb_wpc[BTB_LEN+1:0]};

    // One counter is trained per cycle; its next value also feeds forwarding.
    bp_sat_cnt2 u_upd (
        .cnt_i   (pht_q[bp.id_gshare_windex]),
        .taken_i (bp.id_br_taken),
        .cnt_o   (pht_wr_cnt)
    );

    always_comb begin
        bidx     = bp.if_pc[BTB_LEN+1:2];
        gidx     = bp.if_pc[GHR_LEN+1:2] ^ ghr_q;
        rd_valid = btb_valid_q[bidx];
        rd_tag   = btb_tag_q[bidx];
        rd_tgt   = btb_tgt_q[bidx];
        rd_cnt   = pht_q[gidx];
`ifdef BP_WRITE_FWD_EN
        if (bp.id_btb_wen && (bp.id_btb_windex == bidx)) begin
            rd_valid = 1'b1;
            rd_tag   = pc_tag(bp.id_btb_wpc);
            rd_tgt   = bp.id_btb_wtarget;
        end
        if (bp.id_gshare_wen && (bp.id_gshare_windex == gidx))
            rd_cnt = pht_wr_cnt;
`endif
        hit = rd_valid && (rd_tag == pc_tag(bp.if_pc));
    end

    // Table updates come from a committed stage, so stall/refresh never gate them.
    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        pht_d       = pht_q;
        ghr_d       = ghr_q;
        if (bp.id_btb_wen) begin
            btb_valid_d[bp.id_btb_windex] = 1'b1;
            btb_tag_d[bp.id_btb_windex]   = pc_tag(bp.id_btb_wpc);
            btb_tgt_d[bp.id_btb_windex]   = bp.id_btb_wtarget;
        end
        if (bp.id_gshare_wen) begin
            pht_d[bp.id_gshare_windex] = pht_wr_cnt;
            ghr_d = {ghr_q[GHR_LEN-2:0], bp.id_br_taken};
        end
    end

    // Refresh beats stall; stall holds; otherwise load the new lookup.
    always_comb begin
        pd_valid_d = pd_valid_q;
        pd_hit_d   = pd_hit_q;
        pd_take_d  = pd_take_q;
        pd_tgt_d   = pd_tgt_q;
        pd_bidx_d  = pd_bidx_q;
        pd_gidx_d  = pd_gidx_q;
        if (bp.refresh) begin
            pd_valid_d = 1'b0;
            pd_hit_d   = 1'b0;
            pd_take_d  = 1'b0;
            pd_tgt_d   = '0;
            pd_bidx_d  = '0;
            pd_gidx_d  = '0;
        end else if (!bp.stall) begin
            pd_valid_d = bp.if_req;
            pd_hit_d   = hit;
            pd_take_d  = hit && rd_cnt[1];
            pd_tgt_d   = hit ? rd_tgt : 32'd0;
            pd_bidx_d  = bidx;
            pd_gidx_d  = gidx;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < BTB_BITS; i++) btb_valid_q[i] <= 1'b0;
            for (int i = 0; i < GHR_BITS; i++) pht_q[i] <= WNT;
            ghr_q      <= '0;
            pd_valid_q <= 1'b0;
            pd_hit_q   <= 1'b0;
            pd_take_q  <= 1'b0;
            pd_tgt_q   <= '0;
            pd_bidx_q  <= '0;
            pd_gidx_q  <= '0;
        end else begin
            btb_valid_q <= btb_valid_d;
            pht_q       <= pht_d;
            ghr_q       <= ghr_d;
            pd_valid_q  <= pd_valid_d;
            pd_hit_q    <= pd_hit_d;
            pd_take_q   <= pd_take_d;
            pd_tgt_q    <= pd_tgt_d;
            pd_bidx_q   <= pd_bidx_d;
            pd_gidx_q   <= pd_gidx_d;
        end
    end

    // Tag/target payload needs no reset: the valid bit qualifies it.
    always_ff @(posedge clk) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end

    assign bp.pd_bp_valid     = pd_valid_q;
    assign bp.pd_btb_hit      = pd_hit_q;
    assign bp.pd_bp_take      = pd_take_q;
    assign bp.pd_bp_target    = pd_tgt_q;
    assign bp.pd_btb_index    = pd_bidx_q;
    assign bp.pd_gshare_index = pd_gidx_q;

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Self-checking bench for bp_gshare_btb: directed scenarios plus a random
// run, all compared against a table-level reference model.
module tb_bp_gshare_btb;
    import bp_gshare_btb_pkg::*;

`ifdef BP_WRITE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    bp_gshare_btb_if bif ();

    bp_gshare_btb dut (
        .clk    (clk),
        .resetn (resetn),
        .bp     (bif.slave)
    );

    // Reference model state
    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_pht   [256];
    int          m_ghr;

    logic        e_valid, e_hit, e_take;
    logic [31:0] e_tgt;
    logic [5:0]  e_bidx;
    logic [7:0]  e_gidx;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [48:0] obs();
        return {bif.pd_bp_valid, bif.pd_btb_hit, bif.pd_bp_take, bif.pd_bp_target,
                bif.pd_btb_index, bif.pd_gshare_index};
    endfunction

    function automatic logic [48:0] expv();
        return {e_valid, e_hit, e_take, e_tgt, e_bidx, e_gidx};
    endfunction

    task automatic set_idle();
        bif.stall = 0; bif.refresh = 0; bif.if_req = 0; bif.if_pc = 32'h0;
        bif.id_btb_wen = 0; bif.id_btb_windex = '0; bif.id_btb_wpc = 32'h0;
        bif.id_btb_wtarget = 32'h0; bif.id_gshare_wen = 0;
        bif.id_gshare_windex = '0; bif.id_br_taken = 0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bif.if_req = 1; bif.if_pc = pc;
    endtask

    task automatic btb_wr(input logic [5:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
        bif.id_btb_wen = 1; bif.id_btb_windex = idx; bif.id_btb_wpc = pc; bif.id_btb_wtarget = tgt;
    endtask

    task automatic gs_wr(input logic [7:0] idx, input bit taken);
        bif.id_gshare_wen = 1; bif.id_gshare_windex = idx; bif.id_br_taken = taken;
    endtask

    // Advance one clock: predict the registered outputs from the model
    // (pre-edge tables), then commit the model's table updates.
    task automatic step();
        int bi, gi, cnt, wc;
        bit vv, hit;
        logic [23:0] tg;
        logic [31:0] tt;
        bi = int'((bif.if_pc >> 2) & 32'h3F);
        gi = int'((bif.if_pc >> 2) & 32'hFF) ^ m_ghr;
        wc = m_pht[bif.id_gshare_windex];
        if (bif.id_br_taken) wc = (wc >= 3) ? 3 : wc + 1;
        else                 wc = (wc <= 0) ? 0 : wc - 1;
        vv = m_valid[bi]; tg = m_tag[bi]; tt = m_tgt[bi]; cnt = m_pht[gi];
        if (FWD && bif.id_btb_wen && int'(bif.id_btb_windex) == bi) begin
            vv = 1; tg = bif.id_btb_wpc[31:8]; tt = bif.id_btb_wtarget;
        end
        if (FWD && bif.id_gshare_wen && int'(bif.id_gshare_windex) == gi) cnt = wc;
        hit = vv && (tg == bif.if_pc[31:8]);
        if (!resetn) begin
            e_valid = 0; e_hit = 0; e_take = 0; e_tgt = 0; e_bidx = 0; e_gidx = 0;
            for (int i = 0; i < 64; i++) m_valid[i] = 0;
            for (int i = 0; i < 256; i++) m_pht[i] = 1;
            m_ghr = 0;
        end else begin
            if (bif.refresh) begin
                e_valid = 0; e_hit = 0; e_take = 0; e_tgt = 0; e_bidx = 0; e_gidx = 0;
            end else if (!bif.stall) begin
                e_valid = bif.if_req; e_hit = hit; e_take = hit && (cnt >= 2);
                e_tgt = hit ? tt : 32'h0; e_bidx = 6'(bi); e_gidx = 8'(gi);
            end
            if (bif.id_btb_wen) begin
                m_valid[bif.id_btb_windex] = 1;
                m_tag[bif.id_btb_windex]   = bif.id_btb_wpc[31:8];
                m_tgt[bif.id_btb_windex]   = bif.id_btb_wtarget;
            end
            if (bif.id_gshare_wen) begin
                m_pht[bif.id_gshare_windex] = wc;
                m_ghr = ((m_ghr << 1) | int'(bif.id_br_taken)) & 255;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [48:0] want;
        set_idle(); resetn = 0;
        step(); step();
        n_chk++;
        if (obs() !== 49'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", obs(), 49'h0);
        end
        resetn = 1;
        lookup(32'hBFC00000);
        step();
        want = {1'b1, 1'b0, 1'b0, 32'h0, 6'd0, 8'h00};
        n_chk++;
        if (obs() !== want) begin
            n_fail++; $display("FAIL first_lookup: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_btb_hit();
        logic [48:0] want;
        set_idle(); btb_wr(6'd4, 32'hBFC00010, 32'hBFC00100);
        step();
        set_idle(); lookup(32'hBFC00010);
        step();
        want = {1'b1, 1'b1, 1'b0, 32'hBFC00100, 6'd4, 8'h04};
        n_chk++;
        if (obs() !== want) begin
            n_fail++; $display("FAIL btb_hit: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_gshare();
        logic [48:0] want;
        set_idle(); gs_wr(8'h04, 1); step();
        set_idle(); gs_wr(8'h04, 1); step();
        // GHR now 0x03, so this PC hashes to 0x07 (still weak not-taken)
        set_idle(); lookup(32'hBFC00010); step();
        want = {1'b1, 1'b1, 1'b0, 32'hBFC00100, 6'd4, 8'h07};
        n_chk++;
        if (obs() !== want) begin
            n_fail++; $display("FAIL gshare_hash: got %h want %h", obs(), want);
        end
        // Train 0x07 taken (GHR -> 0x07) and install a BTB entry whose PC hashes to 0x07
        set_idle(); gs_wr(8'h07, 1); btb_wr(6'd0, 32'hBFC00000, 32'hBFC00200); step();
        set_idle(); lookup(32'hBFC00000); step();
        want = {1'b1, 1'b1, 1'b1, 32'hBFC00200, 6'd0, 8'h07};
        n_chk++;
        if (obs() !== want) begin
            n_fail++; $display("FAIL gshare_take: got %h want %h", obs(), want);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] pc;
        set_idle();
        for (int i = 0; i < 4; i++) begin gs_wr(8'h10, 0); step(); end
        gs_wr(8'h10, 1); step();           // 0 -> 1 if the floor held
        set_idle();
        pc = 32'hBFC00000 | (32'((8'h10 ^ 8'(m_ghr))) << 2);
        btb_wr(pc[7:2], pc, 32'h0000_1234); step();
        set_idle(); lookup(pc); step();
        n_chk++;
        if (bif.pd_bp_take !== 1'b0 || obs() !== expv()) begin
            n_fail++; $display("FAIL sat_floor: got %h want %h", obs(), expv());
        end
        set_idle();
        for (int i = 0; i < 5; i++) begin gs_wr(8'h10, 1); step(); end
        gs_wr(8'h10, 0); step();           // 3 -> 2 if the ceiling held
        set_idle();
        pc = 32'hBFC00000 | (32'((8'h10 ^ 8'(m_ghr))) << 2);
        btb_wr(pc[7:2], pc, 32'h0000_5678); step();
        set_idle(); lookup(pc); step();
        n_chk++;
        if (bif.pd_bp_take !== 1'b1 || obs() !== expv()) begin
            n_fail++; $display("FAIL sat_ceiling: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_stall_refresh();
        logic [48:0] snap;
        set_idle(); lookup(32'hBFC00010); step();
        snap = {1'b1, 1'b1, e_take, 32'hBFC00100, 6'd4, e_gidx};
        for (int i = 0; i < 3; i++) begin
            bif.stall = 1; lookup(32'hBFC00000 | (32'($urandom_range(0, 255)) << 2));
            step();
            n_chk++;
            if (obs() !== snap) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs(), snap);
            end
        end
        bif.refresh = 1; bif.stall = 1; step();
        n_chk++;
        if (obs() !== 49'h0) begin
            n_fail++; $display("FAIL refresh_clear: got %h want %h", obs(), 49'h0);
        end
    endtask

    task automatic test_same_cycle();
        set_idle();
        btb_wr(6'd4, 32'hBFC01010, 32'hCAFE0000); lookup(32'hBFC01010); step();
        n_chk++;
        if (bif.pd_btb_hit !== FWD || obs() !== expv()) begin
            n_fail++; $display("FAIL same_cycle_wr: got hit=%b %h want hit=%b %h",
                               bif.pd_btb_hit, obs(), FWD, expv());
        end
        set_idle(); lookup(32'hBFC01010); step();
        n_chk++;
        if (bif.pd_btb_hit !== 1'b1 || bif.pd_bp_target !== 32'hCAFE0000) begin
            n_fail++; $display("FAIL after_wr: got hit=%b tgt=%h want hit=1 tgt=cafe0000",
                               bif.pd_btb_hit, bif.pd_bp_target);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc, wpc;
        for (int i = 0; i < 600; i++) begin
            set_idle();
            pc  = {23'h5FE000 | 23'($urandom_range(0, 1)), 7'($urandom), 2'b00};
            wpc = {23'h5FE000 | 23'($urandom_range(0, 1)), 7'($urandom), 2'b00};
            bif.if_req  = 1'($urandom);
            bif.if_pc   = pc;
            bif.stall   = ($urandom_range(0, 9) < 2);
            bif.refresh = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0)
                btb_wr(($urandom_range(0, 7) == 0) ? 6'($urandom) : wpc[7:2], wpc, $urandom);
            if ($urandom_range(0, 1) == 0)
                gs_wr(($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(pc[9:2] ^ 8'(m_ghr)),
                      1'($urandom));
            step();
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_mid_reset();
        set_idle();
        lookup(32'hBFC00010); btb_wr(6'd4, 32'hBFC00010, 32'h1111);
        gs_wr(8'h04, 1); resetn = 0;
        step();
        n_chk++;
        if (obs() !== 49'h0) begin
            n_fail++; $display("FAIL mid_reset: got %h want %h", obs(), 49'h0);
        end
        resetn = 1;
        for (int i = 0; i < 64; i++) begin
            set_idle(); lookup(32'hBFC00000 | (32'(i) << 2)); step();
            n_chk++;
            if (bif.pd_btb_hit !== 1'b0 || obs() !== expv()) begin
                n_fail++; $display("FAIL reset_valid[%0d]: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        m_ghr = 0;
        test_reset();
        test_btb_hit();
        test_gshare();
        test_saturation();
        test_stall_refresh();
        test_same_cycle();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
